// File: rtl/flux_frame_scheduler.sv
// flux_frame_scheduler: buffers one N-bin magnitude-squared frame from the FFT
// stage, replays it to spectral_flux as a paced mag_valid/mag_sq burst, then
// waits for frame_done before taking the next frame. Short frames are padded
// with zeros and long frames are truncated, so the engine always sees N bins.
//
// Optional feature: define FLUX_SCHED_TIMEOUT_EN to add a frame_done watchdog
// (TMO cycles in WAIT_DONE). Without it, timeout_o is tied low.
//
// state     | meaning
// S_IDLE    | parked, no bins accepted, waiting for enable
// S_FILL    | accepting bins into the frame buffer
// S_RESYNC  | frame overflowed, discarding bins until in_last
// S_DRAIN   | replaying buffer to spectral_flux, GAP idle cycles between bins
// S_WAIT    | burst done, waiting for frame_done (or watchdog)
module flux_frame_scheduler #(
  parameter int W   = 16,
  parameter int N   = 8,
  parameter int GAP = 0,
  parameter int TMO = 256
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         enable_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  input  logic         in_last_i,
  output logic         mag_valid_o,
  output logic [W-1:0] mag_sq_o,
  input  logic         frame_done_i,
  output logic         busy_o,
  output logic [15:0]  frame_count_o,
  output logic         short_frame_o,
  output logic         long_frame_o,
  output logic         timeout_o
);

  localparam int AW = $clog2(N);
  localparam int RW = AW + 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_RESYNC = 3'd2,
    S_DRAIN  = 3'd3,
    S_WAIT   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  mem_q [N];
  logic [W-1:0]  mem_d [N];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [RW-1:0] rptr_q, rptr_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          in_ready_q, in_ready_d;
  logic          mag_valid_q, mag_valid_d;
  logic [W-1:0]  mag_sq_q, mag_sq_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          accept;

`ifdef FLUX_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          timeout_q, timeout_d;
`endif

  assign accept = in_valid_i & in_ready_q;

  // Registered state, buffer, pointers and outputs; reset discards the frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      gap_q         <= '0;
      in_ready_q    <= 1'b0;
      mag_valid_q   <= 1'b0;
      mag_sq_q      <= '0;
      frame_count_q <= '0;
      short_q       <= 1'b0;
      long_q        <= 1'b0;
`ifdef FLUX_SCHED_TIMEOUT_EN
      tmo_q         <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      for (int i = 0; i < N; i++) mem_q[i] <= mem_d[i];
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      gap_q         <= gap_d;
      in_ready_q    <= in_ready_d;
      mag_valid_q   <= mag_valid_d;
      mag_sq_q      <= mag_sq_d;
      frame_count_q <= frame_count_d;
      short_q       <= short_d;
      long_q        <= long_d;
`ifdef FLUX_SCHED_TIMEOUT_EN
      tmo_q         <= tmo_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  // Next-state, buffer writes, drain pacing and frame completion.
  always_comb begin
    state_d       = state_q;
    for (int i = 0; i < N; i++) mem_d[i] = mem_q[i];
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    gap_d         = gap_q;
    mag_valid_d   = 1'b0;
    mag_sq_d      = '0;
    frame_count_d = frame_count_q;
    short_d       = short_q;
    long_d        = long_q;
`ifdef FLUX_SCHED_TIMEOUT_EN
    timeout_d     = timeout_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          state_d = S_FILL;
          wptr_d  = '0;
        end
      end

      S_FILL: begin
        if (accept) begin
          mem_d[wptr_q] = in_data_i;
          wptr_d        = wptr_q + 1'b1;
          if (in_last_i) begin
            // Short frame: pad the unwritten tail so stale bins never replay.
            if (wptr_q != AW'(N - 1)) begin
              short_d = 1'b1;
              for (int i = 0; i < N; i++) begin
                if (i > int'(wptr_q)) mem_d[i] = '0;
              end
            end
            state_d = S_DRAIN;
            rptr_d  = '0;
            gap_d   = '0;
          end else if (wptr_q == AW'(N - 1)) begin
            long_d  = 1'b1;
            state_d = S_RESYNC;
          end
        end
      end

      S_RESYNC: begin
        if (accept && in_last_i) begin
          state_d = S_DRAIN;
          rptr_d  = '0;
          gap_d   = '0;
        end
      end

      S_DRAIN: begin
        // Leave only once the final bin is actually on the output.
        if (rptr_q == RW'(N)) begin
          state_d = S_WAIT;
        end else if (gap_q == '0) begin
          mag_valid_d = 1'b1;
          mag_sq_d    = mem_q[rptr_q[AW-1:0]];
          rptr_d      = rptr_q + 1'b1;
          gap_d       = GW'(GAP);
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end

      S_WAIT: begin
        if (frame_done_i) begin
          frame_count_d = frame_count_q + 16'd1;
          state_d       = enable_i ? S_FILL : S_IDLE;
          wptr_d        = '0;
        end
`ifdef FLUX_SCHED_TIMEOUT_EN
        else if (tmo_q == TW'(TMO - 1)) begin
          timeout_d = 1'b1;
          state_d   = enable_i ? S_FILL : S_IDLE;
          wptr_d    = '0;
        end
`endif
      end

      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_FILL) || (state_d == S_RESYNC);
  end

`ifdef FLUX_SCHED_TIMEOUT_EN
  // Watchdog counts consecutive WAIT cycles and restarts on every exit.
  always_comb begin
    tmo_d = '0;
    if (state_q == S_WAIT && state_d == S_WAIT) tmo_d = tmo_q + 1'b1;
  end
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign in_ready_o    = in_ready_q;
  assign mag_valid_o   = mag_valid_q;
  assign mag_sq_o      = mag_sq_q;
  assign busy_o        = (state_q != S_IDLE);
  assign frame_count_o = frame_count_q;
  assign short_frame_o = short_q;
  assign long_frame_o  = long_q;

endmodule
